// File: rtl/systolic_seq_ctrl_if.sv
// Operand, array-side and result handshake bundle for systolic_seq_ctrl.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface systolic_seq_ctrl_if #(
  parameter int data_width = 8,
  parameter int acc_width  = 16
);
  logic                      start;
  logic [16*data_width-1:0]  a_mat;
  logic [16*data_width-1:0]  b_mat;
  logic                      busy;
  logic                      arr_rst;
  logic                      arr_en;
  logic [4*data_width-1:0]   a_in_flat;
  logic [4*data_width-1:0]   b_in_flat;
  logic [16*acc_width-1:0]   c_out_flat;
  logic [16*acc_width-1:0]   result;
  logic                      result_valid;
  logic                      result_ready;
  logic [15:0]               perf_jobs;
  logic [15:0]               perf_stall;

  modport slave (
    input  start, a_mat, b_mat, c_out_flat, result_ready,
    output busy, arr_rst, arr_en, a_in_flat, b_in_flat, result, result_valid,
           perf_jobs, perf_stall
  );

  modport master (
    output start, a_mat, b_mat, c_out_flat, result_ready,
    input  busy, arr_rst, arr_en, a_in_flat, b_in_flat, result, result_valid,
           perf_jobs, perf_stall
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for systolic_array_4x4: clear, skewed feed, drain, result hold.
// Optional perf counters are enabled by defining SYSTOLIC_PERF_CNT_EN.
module systolic_seq_ctrl #(
  parameter int data_width   = 8,
  parameter int acc_width    = 16,
  parameter int drain_cycles = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  systolic_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                k_q, k_d;
  logic [7:0]                drain_q, drain_d;
  logic [16*data_width-1:0]  opA_q, opB_q;
  logic                      opLoad;
  logic                      captureRes;
  logic                      handshake;
  logic [4*data_width-1:0]   aLane_d, bLane_d;
  int                        lag;

  logic                      busy_q, arrRst_q, arrEn_q, resultValid_q;
  logic [4*data_width-1:0]   aIn_q, bIn_q;
  logic [16*acc_width-1:0]   result_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    drain_d    = drain_q;
    opLoad     = 1'b0;
    captureRes = 1'b0;
    handshake  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opLoad  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        k_d     = 3'd0;
        state_d = FEED;
      end
      FEED: begin
        if (k_q == 3'd6) begin
          drain_d = 8'd0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 8'(drain_cycles - 1)) begin
          captureRes = 1'b1;
          state_d    = HOLD;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      HOLD: begin
        if (resultValid_q && bus.result_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes are computed for the upcoming feed step so they are registered in step with the state.
  always_comb begin
    aLane_d = '0;
    bLane_d = '0;
    lag     = 0;
    if (state_d == FEED) begin
      for (int i = 0; i < 4; i++) begin
        lag = int'(k_d) - i;
        if (lag >= 0 && lag <= 3) begin
          aLane_d[i*data_width +: data_width] = opA_q[(i*4 + lag)*data_width +: data_width];
          bLane_d[i*data_width +: data_width] = opB_q[(lag*4 + i)*data_width +: data_width];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      k_q           <= 3'd0;
      drain_q       <= 8'd0;
      opA_q         <= '0;
      opB_q         <= '0;
      busy_q        <= 1'b0;
      arrRst_q      <= 1'b0;
      arrEn_q       <= 1'b0;
      aIn_q         <= '0;
      bIn_q         <= '0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      busy_q   <= (state_d != IDLE);
      arrRst_q <= (state_d == CLEAR);
      arrEn_q  <= (state_d == FEED) || (state_d == DRAIN);
      aIn_q    <= aLane_d;
      bIn_q    <= bLane_d;
      if (opLoad) begin
        opA_q <= bus.a_mat;
        opB_q <= bus.b_mat;
      end
      if (captureRes) begin
        result_q      <= bus.c_out_flat;
        resultValid_q <= 1'b1;
      end else if (handshake) begin
        resultValid_q <= 1'b0;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.arr_rst      = arrRst_q;
  assign bus.arr_en       = arrEn_q;
  assign bus.a_in_flat    = aIn_q;
  assign bus.b_in_flat    = bIn_q;
  assign bus.result       = result_q;
  assign bus.result_valid = resultValid_q;

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [15:0] jobs_q, stall_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jobs_q  <= 16'd0;
      stall_q <= 16'd0;
    end else begin
      if (handshake && jobs_q != 16'hFFFF)
        jobs_q <= jobs_q + 16'd1;
      if (resultValid_q && !bus.result_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.perf_jobs  = jobs_q;
  assign bus.perf_stall = stall_q;
`else
  assign bus.perf_jobs  = 16'd0;
  assign bus.perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural 4x4 output-stationary array.
// Perf counter expectations follow SYSTOLIC_PERF_CNT_EN.
module tb_systolic_seq_ctrl;

  logic clk;
  logic rst_n;
  int   compareCnt = 0;
  int   failCnt    = 0;
  int   cycleCnt   = 0;

  systolic_seq_ctrl_if #(.data_width(8), .acc_width(16)) seqIf ();

  systolic_seq_ctrl #(.data_width(8), .acc_width(16), .drain_cycles(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (seqIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural array: a moves right, b moves down, each PE accumulates mod 2^16.
  logic [7:0]  peA [4][4];
  logic [7:0]  peB [4][4];
  logic [15:0] acc [4][4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] aLeft, bUp;
        aLeft = (j == 0) ? seqIf.a_in_flat[i*8 +: 8] : peA[i][j-1];
        bUp   = (i == 0) ? seqIf.b_in_flat[j*8 +: 8] : peB[i-1][j];
        if (seqIf.arr_rst) begin
          peA[i][j] <= 8'd0;
          peB[i][j] <= 8'd0;
          acc[i][j] <= 16'd0;
        end else if (seqIf.arr_en) begin
          peA[i][j] <= aLeft;
          peB[i][j] <= bUp;
          acc[i][j] <= acc[i][j] + 16'(16'(aLeft) * 16'(bUp));
        end
      end
    end
  end

  always_comb begin
    seqIf.c_out_flat = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        seqIf.c_out_flat[(i*4 + j)*16 +: 16] = acc[i][j];
  end

  logic [127:0] aRows, bMat, aIdent, allOnes;
  logic [255:0] expIdent, expAllFF;
  logic [63:0]  expRow0, expRow3;

  task automatic tick();
    @(posedge clk);
    #1;
    cycleCnt++;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] check %s differs", tag);
    end
  endtask

  task automatic checkPerf(input string tag, input int expJobs, input int expStall);
`ifdef SYSTOLIC_PERF_CNT_EN
    checkOutput({tag, "_jobs"},  256'(seqIf.perf_jobs),  256'(expJobs));
    checkOutput({tag, "_stall"}, 256'(seqIf.perf_stall), 256'(expStall));
`else
    checkOutput({tag, "_jobs"},  256'(seqIf.perf_jobs),  256'(0 * expJobs));
    checkOutput({tag, "_stall"}, 256'(seqIf.perf_stall), 256'(0 * expStall));
`endif
  endtask

  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b);
    seqIf.a_mat = a;
    seqIf.b_mat = b;
    seqIf.start = 1'b1;
  endtask

  task automatic checkRows(input string tag);
    checkOutput({tag, "_row0"}, 256'(seqIf.result[63:0]),    256'(expRow0));
    checkOutput({tag, "_row3"}, 256'(seqIf.result[255:192]), 256'(expRow3));
  endtask

  // Starts a job in the current IDLE cycle and returns in the first result_valid cycle.
  task automatic runJob(input logic [127:0] a, input logic [127:0] b,
                        input bit detail, input bit corrupt, output int lat);
    int t0;
    t0 = cycleCnt;
    applyStimulus(a, b);
    tick();
    seqIf.start = 1'b0;
    if (corrupt) seqIf.a_mat = '1;
    if (detail) begin
      checkOutput("clear_arr_rst", 256'(seqIf.arr_rst), 256'(1));
      checkOutput("clear_arr_en",  256'(seqIf.arr_en),  256'(0));
      checkOutput("clear_busy",    256'(seqIf.busy),    256'(1));
      tick();
      checkOutput("k0_a",      256'(seqIf.a_in_flat), 256'(32'h0000_0001));
      checkOutput("k0_b",      256'(seqIf.b_in_flat), 256'(32'h0000_0011));
      checkOutput("k0_arr_en", 256'(seqIf.arr_en),    256'(1));
      checkOutput("k0_arr_rst", 256'(seqIf.arr_rst),  256'(0));
      repeat (3) tick();
      checkOutput("k3_a", 256'(seqIf.a_in_flat), 256'(32'h0D0A_0704));
      checkOutput("k3_b", 256'(seqIf.b_in_flat), 256'(32'h1417_1A1D));
      repeat (3) tick();
      checkOutput("k6_a", 256'(seqIf.a_in_flat), 256'(32'h1000_0000));
      checkOutput("k6_b", 256'(seqIf.b_in_flat), 256'(32'h2000_0000));
      tick();
      checkOutput("drain_a",      256'(seqIf.a_in_flat), 256'(0));
      checkOutput("drain_b",      256'(seqIf.b_in_flat), 256'(0));
      checkOutput("drain_arr_en", 256'(seqIf.arr_en),    256'(1));
    end
    while (!seqIf.result_valid && (cycleCnt - t0) < 60) tick();
    lat = cycleCnt - t0;
    checkOutput("result_valid_seen", 256'(seqIf.result_valid), 256'(1));
  endtask

  initial begin
    int lat, vc1, vc2;

    for (int idx = 0; idx < 16; idx++) begin
      aRows[idx*8 +: 8]     = 8'(idx + 1);
      bMat[idx*8 +: 8]      = 8'(idx + 17);
      aIdent[idx*8 +: 8]    = ((idx / 4) == (idx % 4)) ? 8'd1 : 8'd0;
      expIdent[idx*16 +: 16] = 16'(idx + 17);
      expAllFF[idx*16 +: 16] = 16'd63492;
    end
    allOnes = '1;
    expRow0 = {16'd280, 16'd270, 16'd260, 16'd250};
    expRow3 = {16'd1528, 16'd1470, 16'd1412, 16'd1354};

    seqIf.start        = 1'b0;
    seqIf.a_mat        = '0;
    seqIf.b_mat        = '0;
    seqIf.result_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_busy",    256'(seqIf.busy),         256'(0));
    checkOutput("rst_arr_rst", 256'(seqIf.arr_rst),      256'(0));
    checkOutput("rst_arr_en",  256'(seqIf.arr_en),       256'(0));
    checkOutput("rst_a",       256'(seqIf.a_in_flat),    256'(0));
    checkOutput("rst_b",       256'(seqIf.b_in_flat),    256'(0));
    checkOutput("rst_result",  seqIf.result,             256'(0));
    checkOutput("rst_valid",   256'(seqIf.result_valid), 256'(0));
    checkPerf("rst", 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] reset during FEED");
    applyStimulus(aRows, bMat);
    tick();
    seqIf.start = 1'b0;
    repeat (4) tick();
    checkOutput("midrst_k3_a", 256'(seqIf.a_in_flat), 256'(32'h0D0A_0704));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",   256'(seqIf.busy),         256'(0));
    checkOutput("midrst_arr_en", 256'(seqIf.arr_en),       256'(0));
    checkOutput("midrst_a",      256'(seqIf.a_in_flat),    256'(0));
    checkOutput("midrst_b",      256'(seqIf.b_in_flat),    256'(0));
    checkOutput("midrst_valid",  256'(seqIf.result_valid), 256'(0));
    #1 rst_n = 1'b1;
    tick();
    checkOutput("midrst_idle_busy", 256'(seqIf.busy), 256'(0));

    $display("[TB] stalled consumer");
    seqIf.result_ready = 1'b0;
    runJob(aRows, bMat, 1'b0, 1'b0, lat);
    checkOutput("stall_latency", 256'(lat), 256'(17));
    for (int n = 0; n < 5; n++) begin
      seqIf.start = 1'b1;
      checkOutput("stall_busy",  256'(seqIf.busy),         256'(1));
      checkOutput("stall_valid", 256'(seqIf.result_valid), 256'(1));
      checkRows("stall");
      tick();
    end
    seqIf.start        = 1'b0;
    seqIf.result_ready = 1'b1;
    checkPerf("stall_pre", 0, 5);
    tick();
    checkOutput("stall_done_valid", 256'(seqIf.result_valid), 256'(0));
    checkOutput("stall_done_busy",  256'(seqIf.busy),         256'(0));
    checkPerf("stall_post", 1, 5);
    tick();
    checkOutput("stall_no_queue", 256'(seqIf.busy), 256'(0));

    $display("[TB] back-to-back jobs");
    runJob(aRows, bMat, 1'b1, 1'b0, lat);
    vc1 = cycleCnt;
    checkOutput("job1_latency", 256'(lat), 256'(17));
    checkRows("job1");
    tick();
    checkOutput("job1_idle_busy",  256'(seqIf.busy),         256'(0));
    checkOutput("job1_idle_valid", 256'(seqIf.result_valid), 256'(0));
    runJob(aIdent, bMat, 1'b0, 1'b0, lat);
    vc2 = cycleCnt;
    checkOutput("job2_period", 256'(vc2 - vc1), 256'(18));
    checkOutput("job2_identity", seqIf.result, expIdent);
    tick();
    checkPerf("b2b", 3, 5);

    $display("[TB] operand freeze");
    runJob(aRows, bMat, 1'b0, 1'b1, lat);
    checkRows("freeze");
    tick();

    $display("[TB] all-ones operands");
    runJob(allOnes, allOnes, 1'b0, 1'b0, lat);
    checkOutput("ff_result", seqIf.result, expAllFF);
    tick();
    checkPerf("final", 5, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule
